fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of decode; supplies the 32-bit instruction word decode consumes, plus its PC.
- Owns the PC register and issues requests to instruction memory over a valid/ready request channel with an unstallable response channel.
- Holds fetched words in a 2-entry output/skid buffer under decode stall.
- Accepts a redirect (branch/jal/jalr target) from execute and discards stale in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset release.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch byte address, word-aligned
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  instruction data valid (no backpressure)
imem_rsp_data  in  32  returned instruction word
stall  in  1  decode/hazard unit holds the current output
redirect_valid  in  1  load new PC, flush fetched/in-flight words
redirect_pc  in  32  redirect target
out_valid  out  1  instruction presented to decode
out_instruction  out  32  instruction word to decode
out_pc  out  32  address of out_instruction
out_pc_plus4  out  32  out_pc + 4 (mod 2^32)

Behaviour:
- Reset (async assert): pc=RESET_PC, state=REQ, out_valid=0, skid empty, drop=0, out_instruction=32'h0000_0013 (NOP), out_pc=0, out_pc_plus4=4, imem_req_valid=0 while rst is high.
- State machine with one outstanding request maximum:
  - REQ: imem_req_valid=1 and imem_req_addr=pc, but only when the skid is empty. If the skid is full, go to HOLD.
  - REQ on handshake (imem_req_valid && imem_req_ready): inflight_pc<=pc; pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0); go to WAIT.
  - WAIT: on imem_rsp_valid go to REQ. Zero-wait memory therefore yields 1 word per 2 cycles.
  - HOLD: go to REQ once the skid drains.
- Once asserted, imem_req_valid and imem_req_addr stay stable until handshake. The only exception is a redirect, which may replace the address the next cycle.
- Consume: fire = out_valid && !stall.
- Response accepted (not dropped):
  - Output slot empty or fire, skid empty: out<=rsp.
  - fire with skid full: out<=skid, skid<=rsp.
  - Output held (out_valid && stall): skid<=rsp. The issue rule guarantees the skid is empty here.
- fire with no response: out<=skid if the skid is full, else out_valid<=0.
- Output latency: response cycle +1 (registered outputs).
- Redirect (highest priority, beats stall and beats a same-cycle response):
  - out_valid<=0, skid emptied, pc<=redirect_pc.
  - If a request is outstanding, including one handshaking the same cycle: drop<=1, state WAIT. Otherwise state REQ.
  - A response arriving while drop=1 is discarded; drop clears and state goes to REQ.
  - A response in the same cycle as redirect_valid is always discarded.
- Stall with out_valid=0: no effect on the output; fetch continues.
- Back-to-back redirects: the last one wins; drop is asserted at most once per outstanding request.
- Reset mid-WAIT: the pending response is ignored. Memory is reset by the same rst.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - redirect_pc[1:0]!=0 asserts the extra output port fetch_misaligned (1 bit, reset 0).
  - No request is issued; out_valid stays 0 until the next aligned redirect, which clears the flag.
- Undefined: the port is absent; redirect_pc[1:0] is forced to 2'b00.

Test Plan:
- Reset release, RESET_PC=0, imem ready=1, 1-cycle response returning 0x00500093 -> first imem_req_addr=0x0, out_valid with out_instruction=0x00500093, out_pc=0, out_pc_plus4=4; next request at 0x4.
- imem_req_ready low for 3 cycles -> imem_req_valid held 1, addr stable at 0x4, no pc increment until handshake.
- stall held 6 cycles while words at 0x8 and 0xC return -> output holds 0x8, skid holds 0xC, no request issued while the skid is full; release -> 0x8 then 0xC on consecutive cycles, then fetch resumes at 0x10.
- redirect_valid to 0x100 during WAIT for 0x14 -> response for 0x14 discarded, next request 0x100, out_pc=0x100; no 0x14 ever presented.
- redirect_valid to 0x200 same cycle as imem_rsp_valid and stall=1 -> response dropped, out_valid=0 next cycle, request to 0x200.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned=1, no requests; redirect to 0x104 -> flag clears, fetch at 0x104.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory request (valid/ready) and response (valid
//            only) channel between the fetch stage and instruction memory.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch: PC register, one outstanding imem request,
//            2-entry output/skid buffer and redirect flush. The optional
//            misaligned-redirect flag is built when FETCH_ALIGN_CHECK_EN is
//            defined.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire          clk,
   input  wire          rst,
   fetch_stage_if.master imem,
   input  wire          stall,
   input  wire          redirect_valid,
   input  wire  [31:0]  redirect_pc,
   output logic         out_valid,
   output logic [31:0]  out_instruction,
   output logic [31:0]  out_pc,
   output logic [31:0]  out_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic         fetch_misaligned
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [31:0] c_nop_instr = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   logic        r_drop;
   logic        r_req_en;
   logic        r_misaligned;
   logic        r_skid_valid;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;

   logic [31:0] w_redirect_pc;
   logic        w_redirect_bad;
   logic        w_handshake;
   logic        w_outstanding;
   logic        w_rsp_accept;
   logic        w_fire;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_redirect_pc    = redirect_pc;
   assign w_redirect_bad   = |redirect_pc[1:0];
   assign fetch_misaligned = r_misaligned;
`else
   logic w_unused_lsbs;
   assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
   assign w_redirect_bad = 1'b0;
   assign w_unused_lsbs  = ^redirect_pc[1:0];
`endif

   // r_req_en keeps the request low for the first cycle out of reset.
   assign imem.req_valid = r_req_en && !r_misaligned && (r_state == S_REQ) && !r_skid_valid;
   assign imem.req_addr  = r_pc;

   assign w_handshake   = imem.req_valid && imem.req_ready;
   assign w_outstanding = ((r_state == S_WAIT) && !imem.rsp_valid) || w_handshake;
   assign w_rsp_accept  = (r_state == S_WAIT) && imem.rsp_valid && !r_drop;
   assign w_fire        = out_valid && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_REQ;
         r_pc            <= RESET_PC;
         r_inflight_pc   <= RESET_PC;
         r_drop          <= 1'b0;
         r_req_en        <= 1'b0;
         r_misaligned    <= 1'b0;
         r_skid_valid    <= 1'b0;
         r_skid_instr    <= c_nop_instr;
         r_skid_pc       <= 32'h0000_0000;
         out_valid       <= 1'b0;
         out_instruction <= c_nop_instr;
         out_pc          <= 32'h0000_0000;
         out_pc_plus4    <= 32'h0000_0004;
      end else begin
         r_req_en <= 1'b1;
         if (redirect_valid) begin
            // A same-cycle response retires its request, so nothing is left to drop.
            r_pc         <= w_redirect_pc;
            r_misaligned <= w_redirect_bad;
            r_drop       <= w_outstanding;
            r_state      <= w_outstanding ? S_WAIT : S_REQ;
            r_skid_valid <= 1'b0;
            out_valid    <= 1'b0;
         end else begin
            case (r_state)
               S_REQ: begin
                  if (r_skid_valid) begin
                     r_state <= S_HOLD;
                  end else if (w_handshake) begin
                     r_inflight_pc <= r_pc;
                     r_pc          <= r_pc + 32'd4;
                     r_state       <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem.rsp_valid) begin
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end
               end
               S_HOLD: begin
                  if (!r_skid_valid) begin
                     r_state <= S_REQ;
                  end
               end
               default: r_state <= S_REQ;
            endcase

            if (w_rsp_accept) begin
               if (out_valid && stall) begin
                  r_skid_valid <= 1'b1;
                  r_skid_instr <= imem.rsp_data;
                  r_skid_pc    <= r_inflight_pc;
               end else if (r_skid_valid) begin
                  out_valid       <= 1'b1;
                  out_instruction <= r_skid_instr;
                  out_pc          <= r_skid_pc;
                  out_pc_plus4    <= r_skid_pc + 32'd4;
                  r_skid_instr    <= imem.rsp_data;
                  r_skid_pc       <= r_inflight_pc;
               end else begin
                  out_valid       <= 1'b1;
                  out_instruction <= imem.rsp_data;
                  out_pc          <= r_inflight_pc;
                  out_pc_plus4    <= r_inflight_pc + 32'd4;
               end
            end else if (w_fire) begin
               if (r_skid_valid) begin
                  out_instruction <= r_skid_instr;
                  out_pc          <= r_skid_pc;
                  out_pc_plus4    <= r_skid_pc + 32'd4;
                  r_skid_valid    <= 1'b0;
               end else begin
                  out_valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized traffic against an in-order fetch-stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;
   localparam logic [31:0] c_reset_pc = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   fetch_stage_if imem();

   fetch_stage #(.RESET_PC(c_reset_pc)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem            (imem),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_pc_plus4    (out_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .fetch_misaligned(fetch_misaligned)
`endif
   );

   int checks = 0;
   int errors = 0;
   int fires  = 0;

   // memory environment: ready mode 0=random,1=always,2=never; latency 0=random 1..3
   int          mem_ready_mode = 1;
   int          mem_lat        = 1;
   bit          mem_busy       = 0;
   int          mem_cnt        = 0;
   logic [31:0] mem_addr       = 32'h0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input string name, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!imem.req_valid && n < max);
      if (!imem.req_valid) timeout(name);
   endtask

   task automatic wait_req_addr(input string name, input logic [31:0] a, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem.req_valid && imem.req_addr == a) && n < max);
      if (!(imem.req_valid && imem.req_addr == a)) timeout(name);
   endtask

   task automatic wait_out(input string name, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < max);
      if (!out_valid) timeout(name);
   endtask

   task automatic wait_out_pc(input string name, input logic [31:0] a, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_pc == a) && n < max);
      if (!(out_valid && out_pc == a)) timeout(name);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Instruction memory: one request at a time, response after 1..3 cycles.
   initial begin
      bit          hs;
      logic [31:0] hs_addr;
      imem.req_ready = 1'b0;
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         hs      = !rst && imem.req_valid && imem.req_ready;
         hs_addr = imem.req_addr;
         @(posedge clk);
         #2;
         imem.rsp_valid = 1'b0;
         imem.rsp_data  = $urandom;
         if (rst) begin
            mem_busy = 0;
         end else begin
            if (hs) begin
               mem_busy = 1;
               mem_addr = hs_addr;
               mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (mem_busy) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  imem.rsp_valid = 1'b1;
                  imem.rsp_data  = memf(mem_addr);
                  mem_busy       = 0;
               end
            end
         end
         case (mem_ready_mode)
            0:       imem.req_ready = ($urandom_range(0, 9) < 7);
            1:       imem.req_ready = 1'b1;
            default: imem.req_ready = 1'b0;
         endcase
      end
   end

   // Reference: decode sees a gap-free word stream starting at the last
   // redirect target; requests walk the same addresses one word at a time.
   initial begin
      logic [31:0] exp_pc, exp_req, hold_pc, tgt;
      bit          red_prev, hold_prev, reqwait_prev;
`ifdef FETCH_ALIGN_CHECK_EN
      bit          exp_mis = 0;
`endif
      exp_pc = c_reset_pc; exp_req = c_reset_pc; hold_pc = 32'h0;
      red_prev = 0; hold_prev = 0; reqwait_prev = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_pc = c_reset_pc; exp_req = c_reset_pc;
            red_prev = 0; hold_prev = 0; reqwait_prev = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            exp_mis = 0;
`endif
         end else begin
            if (red_prev) chk("flush_out_valid", out_valid, 1'b0);
            if (hold_prev) begin
               chk("hold_valid", out_valid, 1'b1);
               chk("hold_pc", out_pc, hold_pc);
            end
            if (reqwait_prev) chk("req_held", imem.req_valid, 1'b1);
            if (imem.req_valid) begin
               chk("req_addr", imem.req_addr, exp_req);
               chk("single_outstanding", mem_busy || imem.rsp_valid, 1'b0);
            end
            if (out_valid) begin
               chk("out_pc", out_pc, exp_pc);
               chk("out_instruction", out_instruction, memf(exp_pc));
               chk("out_pc_plus4", out_pc_plus4, exp_pc + 32'd4);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            chk("misaligned_flag", fetch_misaligned, exp_mis);
            if (exp_mis) chk("misaligned_idle", imem.req_valid || out_valid, 1'b0);
`endif
            red_prev     = redirect_valid;
            hold_prev    = out_valid && stall && !redirect_valid;
            hold_pc      = out_pc;
            reqwait_prev = imem.req_valid && !imem.req_ready && !redirect_valid;
            if (out_valid && !stall) begin
               exp_pc = exp_pc + 32'd4;
               fires++;
            end
            if (imem.req_valid && imem.req_ready) exp_req = exp_req + 32'd4;
            if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
               tgt     = redirect_pc;
               exp_mis = (redirect_pc[1:0] != 2'b00);
`else
               tgt = {redirect_pc[31:2], 2'b00};
`endif
               exp_pc  = tgt;
               exp_req = tgt;
            end
         end
      end
   end

   initial begin
      logic [31:0] r;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      mem_ready_mode = 1; mem_lat = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", imem.req_valid, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_instruction", out_instruction, 32'h0000_0013);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_pc_plus4", out_pc_plus4, 32'h4);
      tick();
      rst = 1'b0;

      // first fetch, then request 0x4 stuck behind ready low
      wait_req("first_req", 20);
      chk("first_req_addr", imem.req_addr, 32'h0);
      mem_ready_mode = 2;
      wait_out("first_out", 20);
      chk("first_out_instruction", out_instruction, 32'h0050_0093);
      chk("first_out_pc", out_pc, 32'h0);
      chk("first_out_pc_plus4", out_pc_plus4, 32'h4);
      chk("second_req_valid", imem.req_valid, 1'b1);
      chk("second_req_addr", imem.req_addr, 32'h4);
      repeat (3) begin
         @(negedge clk);
         chk("ready_low_valid", imem.req_valid, 1'b1);
         chk("ready_low_addr", imem.req_addr, 32'h4);
      end
      mem_ready_mode = 1;

      // stall while 0x8 and 0xC return
      wait_out_pc("out_0x4", 32'h4, 20);
      tick();
      stall = 1'b1;
      repeat (6) @(negedge clk);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_pc", out_pc, 32'h8);
      chk("stall_no_req", imem.req_valid, 1'b0);
      tick();
      stall = 1'b0;
      @(negedge clk);
      chk("release_first_pc", out_pc, 32'h8);
      @(negedge clk);
      chk("release_second_valid", out_valid, 1'b1);
      chk("release_second_pc", out_pc, 32'hC);
      wait_req("resume_req", 20);
      chk("resume_req_addr", imem.req_addr, 32'h10);

      // redirect while waiting on 0x14
      wait_req_addr("req_0x14", 32'h14, 30);
      mem_lat = 3;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      wait_req("req_after_redirect", 20);
      chk("redirect_req_addr", imem.req_addr, 32'h100);
      mem_lat = 1;
      wait_out("out_after_redirect", 20);
      chk("redirect_out_pc", out_pc, 32'h100);

      // redirect colliding with a response under stall
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("collide_out_valid", out_valid, 1'b0);
      chk("collide_req_valid", imem.req_valid, 1'b1);
      chk("collide_req_addr", imem.req_addr, 32'h200);
      tick();
      stall = 1'b0;

      // randomized traffic with one mid-run reset
      mem_ready_mode = 0; mem_lat = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (i == 2000) begin
            #1;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            rst = 1'b0;
         end
         r = $urandom;
         stall          = ($urandom_range(0, 9) < 3);
         redirect_valid = ($urandom_range(0, 31) == 0);
         redirect_pc    = $urandom;
         if (r[3:0] == 4'h0) redirect_pc[31:4] = 28'hFFF_FFFF;
`ifdef FETCH_ALIGN_CHECK_EN
         redirect_pc[1:0] = 2'b00;
`endif
      end
      tick();
      stall = 1'b0; redirect_valid = 1'b0;
      mem_ready_mode = 1; mem_lat = 1;
      repeat (10) @(negedge clk);

`ifdef FETCH_ALIGN_CHECK_EN
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("mis_flag_set", fetch_misaligned, 1'b1);
      chk("mis_no_req", imem.req_valid, 1'b0);
      chk("mis_no_out", out_valid, 1'b0);
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h104;
      tick();
      redirect_valid = 1'b0;
      wait_req("mis_recover_req", 20);
      chk("mis_recover_addr", imem.req_addr, 32'h104);
      chk("mis_flag_clear", fetch_misaligned, 1'b0);
      repeat (10) @(negedge clk);
`endif

      chk("liveness", fires > 300, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
